// File: rtl/ddr2_mem_scoreboard.sv
// ddr2_mem_scoreboard
// Shadow-memory checker for the behavioural DDR2 model. Tracks write commits in
// a register-based shadow copy, compares every read beat against it, checks
// read-burst framing (sequential addresses, bounded gaps) and keeps counters
// plus first/last error capture registers for the testbench.
module ddr2_mem_scoreboard #(
    parameter int DEPTH     = 1024,
    parameter int BURST_LEN = 8,
    parameter int GAP_MAX   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dbg_wr_valid,
    input  logic [31:0] dbg_wr_addr,
    input  logic [15:0] dbg_wr_data,
    input  logic        dbg_rd_valid,
    input  logic [31:0] dbg_rd_addr,
    input  logic [15:0] dbg_rd_data,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic [15:0] err_exp,
    output logic [15:0] err_got,
    output logic [31:0] first_err_addr,
    output logic [15:0] first_err_exp,
    output logic [15:0] first_err_got,
    output logic        first_err_seen,
    output logic        burst_done,
    output logic        burst_err,
    output logic [15:0] wr_burst_cnt,
    output logic [15:0] rd_burst_cnt,
    output logic [31:0] rd_beat_cnt,
    output logic [15:0] err_cnt,
    output logic        pass
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = $clog2(GAP_MAX + 2);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Shadow memory: one register per word so that a whole write burst
    // (BURST_LEN words, possibly wrapping) lands in a single cycle and the
    // array can be cleared by reset to match the model's power-up state.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][15:0] shadow_words;
    logic [AW-1:0]          wr_idx;
    logic [AW-1:0]          rd_idx;
    logic                   unused_wr_hi;

    assign wr_idx       = dbg_wr_addr[AW-1:0];
    assign rd_idx       = dbg_rd_addr[AW-1:0];
    // Upper write-address bits do not select a shadow word.
    assign unused_wr_hi = &{1'b0, dbg_wr_addr[31:AW]};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shadow
            logic [15:0]   word_reg;
            logic [AW-1:0] offset;

            // Distance from the burst base, modulo DEPTH, gives the wrap for free.
            assign offset = AW'(gi) - wr_idx;

            // Word is written when it falls inside the committed burst window.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= 16'h0000;
                end else if (dbg_wr_valid && (offset < AW'(BURST_LEN))) begin
                    word_reg <= dbg_wr_data;
                end
            end

            assign shadow_words[gi] = word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read compare. The expected word is taken from the current register
    // contents, so a same-cycle write is not yet visible to the compare.
    // Case inequality makes any X/Z in the beat data a mismatch.
    // ------------------------------------------------------------------
    logic [15:0] exp_word;
    logic        mismatch;

    assign exp_word = shadow_words[rd_idx];
    assign mismatch = dbg_rd_valid && (dbg_rd_data !== exp_word);

    // ------------------------------------------------------------------
    // Burst framing FSM
    // ------------------------------------------------------------------
    state_t        state_reg,  state_next;
    logic [BW-1:0] beat_reg,   beat_next;
    logic [31:0]   base_reg,   base_next;
    logic [GW-1:0] gap_reg,    gap_next;
    logic          done_next;
    logic          berr_next;

    // Next-state and pulse decode for the burst tracker.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        base_next  = base_reg;
        gap_next   = gap_reg;
        done_next  = 1'b0;
        berr_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dbg_rd_valid) begin
                    state_next = BURST;
                    base_next  = dbg_rd_addr;
                    beat_next  = BW'(1);
                    gap_next   = '0;
                end
            end
            BURST: begin
                if (dbg_rd_valid) begin
                    gap_next = '0;
                    if (dbg_rd_addr != (base_reg + 32'(beat_reg))) begin
                        // Out-of-sequence beat: flag it and treat it as a new beat 0.
                        berr_next = 1'b1;
                        base_next = dbg_rd_addr;
                        beat_next = BW'(1);
                    end else if (beat_reg == BW'(BURST_LEN - 1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat_reg + BW'(1);
                    end
                end else if (gap_reg == GW'(GAP_MAX)) begin
                    // This idle cycle pushes the gap past the limit.
                    berr_next  = 1'b1;
                    state_next = IDLE;
                    beat_next  = '0;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state registers; reset silently abandons any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            base_reg  <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            base_reg  <= base_next;
            gap_reg   <= gap_next;
        end
    end

    // ------------------------------------------------------------------
    // Error capture: last mismatch held until the next one, first one sticky.
    // ------------------------------------------------------------------
    logic        err_valid_reg;
    logic [31:0] err_addr_reg;
    logic [15:0] err_exp_reg;
    logic [15:0] err_got_reg;
    logic [31:0] first_addr_reg;
    logic [15:0] first_exp_reg;
    logic [15:0] first_got_reg;
    logic        first_seen_reg;

    // Registered mismatch report, one cycle after the offending beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_valid_reg  <= 1'b0;
            err_addr_reg   <= '0;
            err_exp_reg    <= '0;
            err_got_reg    <= '0;
            first_addr_reg <= '0;
            first_exp_reg  <= '0;
            first_got_reg  <= '0;
            first_seen_reg <= 1'b0;
        end else begin
            err_valid_reg <= mismatch;
            if (mismatch) begin
                err_addr_reg <= dbg_rd_addr;
                err_exp_reg  <= exp_word;
                err_got_reg  <= dbg_rd_data;
                if (!first_seen_reg) begin
                    first_addr_reg <= dbg_rd_addr;
                    first_exp_reg  <= exp_word;
                    first_got_reg  <= dbg_rd_data;
                    first_seen_reg <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and burst pulses
    // ------------------------------------------------------------------
    logic        burst_done_reg;
    logic        burst_err_reg;
    logic [15:0] wr_burst_cnt_reg;
    logic [15:0] rd_burst_cnt_reg;
    logic [31:0] rd_beat_cnt_reg;
    logic [15:0] err_cnt_reg;
    logic [16:0] err_sum;

    // A beat can be both a data mismatch and a framing error: count both.
    assign err_sum = {1'b0, err_cnt_reg} + {16'd0, mismatch} + {16'd0, berr_next};

    // Statistics counters; err_cnt saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_done_reg   <= 1'b0;
            burst_err_reg    <= 1'b0;
            wr_burst_cnt_reg <= '0;
            rd_burst_cnt_reg <= '0;
            rd_beat_cnt_reg  <= '0;
            err_cnt_reg      <= '0;
        end else begin
            burst_done_reg <= done_next;
            burst_err_reg  <= berr_next;
            if (dbg_wr_valid) begin
                wr_burst_cnt_reg <= wr_burst_cnt_reg + 16'd1;
            end
            if (done_next) begin
                rd_burst_cnt_reg <= rd_burst_cnt_reg + 16'd1;
            end
            if (dbg_rd_valid) begin
                rd_beat_cnt_reg <= rd_beat_cnt_reg + 32'd1;
            end
            err_cnt_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_valid      = err_valid_reg;
    assign err_addr       = err_addr_reg;
    assign err_exp        = err_exp_reg;
    assign err_got        = err_got_reg;
    assign first_err_addr = first_addr_reg;
    assign first_err_exp  = first_exp_reg;
    assign first_err_got  = first_got_reg;
    assign first_err_seen = first_seen_reg;
    assign burst_done     = burst_done_reg;
    assign burst_err      = burst_err_reg;
    assign wr_burst_cnt   = wr_burst_cnt_reg;
    assign rd_burst_cnt   = rd_burst_cnt_reg;
    assign rd_beat_cnt    = rd_beat_cnt_reg;
    assign err_cnt        = err_cnt_reg;
    assign pass           = (err_cnt_reg == 16'd0) && (state_reg == IDLE);

endmodule

// File: tb/tb_ddr2_mem_scoreboard.sv
// Testbench for ddr2_mem_scoreboard: vector table with per-cycle expected
// pulses pushed to a scoreboard queue, plus hand checks of counters, sticky
// capture and reset behaviour between groups.
module tb_ddr2_mem_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_wr_valid;
    logic [31:0] dbg_wr_addr;
    logic [15:0] dbg_wr_data;
    logic        dbg_rd_valid;
    logic [31:0] dbg_rd_addr;
    logic [15:0] dbg_rd_data;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [15:0] err_exp;
    logic [15:0] err_got;
    logic [31:0] first_err_addr;
    logic [15:0] first_err_exp;
    logic [15:0] first_err_got;
    logic        first_err_seen;
    logic        burst_done;
    logic        burst_err;
    logic [15:0] wr_burst_cnt;
    logic [15:0] rd_burst_cnt;
    logic [31:0] rd_beat_cnt;
    logic [15:0] err_cnt;
    logic        pass;

    always #5 clk = ~clk;

    ddr2_mem_scoreboard #(.DEPTH(1024), .BURST_LEN(8), .GAP_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .dbg_wr_valid(dbg_wr_valid), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .dbg_rd_valid(dbg_rd_valid), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
        .err_valid(err_valid), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
        .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
        .first_err_got(first_err_got), .first_err_seen(first_err_seen),
        .burst_done(burst_done), .burst_err(burst_err),
        .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt),
        .rd_beat_cnt(rd_beat_cnt), .err_cnt(err_cnt), .pass(pass)
    );

    typedef struct {
        bit          wv;
        logic [31:0] wa;
        logic [15:0] wd;
        bit          rv;
        logic [31:0] ra;
        logic [15:0] rd;
        bit          ee;   // expect err_valid
        bit          ed;   // expect burst_done
        bit          eb;   // expect burst_err
        logic [31:0] xa;   // expected err_addr when ee
        logic [15:0] xe;   // expected err_exp when ee
        logic [15:0] xg;   // expected err_got when ee
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   gs[7];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(bit wv, logic [31:0] wa, logic [15:0] wd, bit rv,
                                logic [31:0] ra, logic [15:0] rd, bit ee, bit ed, bit eb,
                                logic [31:0] xa, logic [15:0] xe, logic [15:0] xg);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rd = rd;
        v.ee = ee; v.ed = ed; v.eb = eb; v.xa = xa; v.xe = xe; v.xg = xg;
        return v;
    endfunction

    // Good read beat (no data error expected)
    function automatic vec_t rb(logic [31:0] a, logic [15:0] d, bit ed, bit eb);
        return mk(0, 0, 0, 1, a, d, 0, ed, eb, 0, 0, 0);
    endfunction
    // Read beat with an expected data mismatch
    function automatic vec_t rbad(logic [31:0] a, logic [15:0] d, logic [15:0] xe, bit ed, bit eb);
        return mk(0, 0, 0, 1, a, d, 1, ed, eb, a, xe, d);
    endfunction
    function automatic vec_t wr(logic [31:0] a, logic [15:0] d);
        return mk(1, a, d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t idle(bit eb);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, eb, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one vector, push its expectation, compare one cycle later.
    task automatic apply(input int i);
        vec_t v;
        vec_t e;
        v = tbl[i];
        dbg_wr_valid = v.wv; dbg_wr_addr = v.wa; dbg_wr_data = v.wd;
        dbg_rd_valid = v.rv; dbg_rd_addr = v.ra; dbg_rd_data = v.rd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        dbg_wr_valid = 1'b0;
        dbg_rd_valid = 1'b0;
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", i), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d err_valid", i), 32'(err_valid), 32'(e.ee));
            chk($sformatf("v%0d burst_done", i), 32'(burst_done), 32'(e.ed));
            chk($sformatf("v%0d burst_err", i), 32'(burst_err), 32'(e.eb));
            if (e.ee) begin
                chk($sformatf("v%0d err_addr", i), err_addr, e.xa);
                chk($sformatf("v%0d err_exp", i), 32'(err_exp), 32'(e.xe));
                chk($sformatf("v%0d err_got", i), 32'(err_got), 32'(e.xg));
            end
        end
        $display("[TB] vec %0d wr=%0d@%h rd=%0d@%h d=%h -> err=%0d done=%0d berr=%0d cnt=%0d",
                 i, v.wv, v.wa, v.rv, v.ra, v.rd, err_valid, burst_done, burst_err, err_cnt);
    endtask

    task automatic run_group(input int g);
        for (int i = gs[g]; i < gs[g+1]; i++) apply(i);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " err_valid"}, 32'(err_valid), 0);
        chk({tag, " err_addr"}, err_addr, 0);
        chk({tag, " first_err_seen"}, 32'(first_err_seen), 0);
        chk({tag, " first_err_addr"}, first_err_addr, 0);
        chk({tag, " burst_done"}, 32'(burst_done), 0);
        chk({tag, " burst_err"}, 32'(burst_err), 0);
        chk({tag, " wr_burst_cnt"}, 32'(wr_burst_cnt), 0);
        chk({tag, " rd_burst_cnt"}, 32'(rd_burst_cnt), 0);
        chk({tag, " rd_beat_cnt"}, rd_beat_cnt, 0);
        chk({tag, " err_cnt"}, 32'(err_cnt), 0);
        chk({tag, " pass"}, 32'(pass), 1);
    endtask

    // Assert reset away from an edge, verify the asynchronous clear, release.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        check_zero({tag, " async"});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero({tag, " released"});
        $display("[TB] reset %s done", tag);
    endtask

    initial begin
        reset = 1'b1;
        dbg_wr_valid = 1'b0; dbg_wr_addr = '0; dbg_wr_data = '0;
        dbg_rd_valid = 1'b0; dbg_rd_addr = '0; dbg_rd_data = '0;

        // Group 0: clean write + burst
        gs[0] = tbl.size();
        tbl.push_back(wr(32'h10, 16'hA5A5));
        for (int a = 0; a < 8; a++) tbl.push_back(rb(32'h10 + a, 16'hA5A5, a == 7, 0));
        tbl.push_back(idle(0));
        // Group 1: mismatch on beat 3, second mismatch, gap timeout
        gs[1] = tbl.size();
        for (int a = 0; a < 8; a++) begin
            if (a == 3) tbl.push_back(rbad(32'h13, 16'hA5A4, 16'hA5A5, 0, 0));
            else        tbl.push_back(rb(32'h10 + a, 16'hA5A5, a == 7, 0));
        end
        tbl.push_back(rbad(32'h10, 16'h0000, 16'hA5A5, 0, 0));
        tbl.push_back(idle(0)); tbl.push_back(idle(0)); tbl.push_back(idle(1));
        // Group 2: unwritten region reads 0, same-cycle write uses old value
        gs[2] = tbl.size();
        for (int a = 0; a < 8; a++) tbl.push_back(rb(32'h40 + a, 16'h0000, a == 7, 0));
        tbl.push_back(mk(1, 32'h40, 16'h1234, 1, 32'h40, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rb(32'h41, 16'h1234, 0, 0));
        tbl.push_back(rb(32'h40, 16'h1234, 0, 1));
        tbl.push_back(idle(0)); tbl.push_back(idle(0)); tbl.push_back(idle(1));
        // Group 3: write window wraps past DEPTH
        gs[3] = tbl.size();
        tbl.push_back(wr(32'h3FC, 16'hBEEF));
        for (int a = 0; a < 8; a++) tbl.push_back(rb(32'h3FC + a, 16'hBEEF, a == 7, 0));
        tbl.push_back(idle(0));
        // Group 4: gap of exactly GAP_MAX tolerated, then GAP_MAX+1 times out
        gs[4] = tbl.size();
        tbl.push_back(rb(32'h60, 0, 0, 0)); tbl.push_back(rb(32'h61, 0, 0, 0));
        tbl.push_back(idle(0)); tbl.push_back(idle(0));
        for (int a = 2; a < 8; a++) tbl.push_back(rb(32'h60 + a, 0, a == 7, 0));
        for (int a = 0; a < 5; a++) tbl.push_back(rb(32'h50 + a, 0, 0, 0));
        tbl.push_back(idle(0)); tbl.push_back(idle(0)); tbl.push_back(idle(1));
        tbl.push_back(rb(32'h99, 0, 0, 0));
        tbl.push_back(idle(0));
        // Group 5: out-of-sequence beat restarts burst; mismatch + burst_err together
        gs[5] = tbl.size();
        tbl.push_back(rb(32'h20, 0, 0, 0)); tbl.push_back(rb(32'h21, 0, 0, 0));
        tbl.push_back(rb(32'h23, 0, 0, 1)); tbl.push_back(rb(32'h24, 0, 0, 0));
        tbl.push_back(rbad(32'h10, 16'hA5A5, 16'h0000, 0, 1));
        tbl.push_back(idle(0));
        gs[6] = tbl.size();

        #3;
        do_reset("initial");

        run_group(0);
        chk("g0 wr_burst_cnt", 32'(wr_burst_cnt), 1);
        chk("g0 rd_burst_cnt", 32'(rd_burst_cnt), 1);
        chk("g0 rd_beat_cnt", rd_beat_cnt, 8);
        chk("g0 err_cnt", 32'(err_cnt), 0);
        chk("g0 pass", 32'(pass), 1);

        run_group(1);
        chk("g1 rd_burst_cnt", 32'(rd_burst_cnt), 2);
        chk("g1 rd_beat_cnt", rd_beat_cnt, 17);
        chk("g1 err_cnt", 32'(err_cnt), 3);
        chk("g1 first_err_seen", 32'(first_err_seen), 1);
        chk("g1 first_err_addr", first_err_addr, 32'h13);
        chk("g1 first_err_exp", 32'(first_err_exp), 32'hA5A5);
        chk("g1 first_err_got", 32'(first_err_got), 32'hA5A4);
        chk("g1 err_addr_held", err_addr, 32'h10);
        chk("g1 err_got_held", 32'(err_got), 0);
        chk("g1 pass", 32'(pass), 0);
        do_reset("g1");

        run_group(2);
        chk("g2 wr_burst_cnt", 32'(wr_burst_cnt), 1);
        chk("g2 rd_burst_cnt", 32'(rd_burst_cnt), 1);
        chk("g2 rd_beat_cnt", rd_beat_cnt, 11);
        chk("g2 err_cnt", 32'(err_cnt), 2);
        chk("g2 first_err_seen", 32'(first_err_seen), 0);
        do_reset("g2");

        run_group(3);
        chk("g3 rd_burst_cnt", 32'(rd_burst_cnt), 1);
        chk("g3 err_cnt", 32'(err_cnt), 0);
        chk("g3 pass", 32'(pass), 1);
        do_reset("g3");

        run_group(4);
        chk("g4 rd_burst_cnt", 32'(rd_burst_cnt), 1);
        chk("g4 rd_beat_cnt", rd_beat_cnt, 14);
        chk("g4 err_cnt", 32'(err_cnt), 1);
        do_reset("g4");

        run_group(5);
        chk("g5 err_cnt", 32'(err_cnt), 3);
        chk("g5 rd_beat_cnt", rd_beat_cnt, 5);
        chk("g5 first_err_addr", first_err_addr, 32'h10);
        chk("g5 pass_mid_burst", 32'(pass), 0);
        do_reset("mid_burst");

        chk("scoreboard drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
